eqp_meas_ctrl: RTL and testbench
================================

Name: eqp_meas_ctrl

Overview:
Measurement sequencer for the equal-precision frequency meter. It opens a preset gate of a selectable length in reference clocks, aligns the real gate to rising edges of the measured signal fx, and counts both fx periods and reference cycles inside that gate. On completion it presents one result pair, from which downstream logic computes f = f_clk * nsig / nref. It sits between the clock divider and the display/arithmetic stage, and replaces the free-running decade gates for measurement timing.

Parameters:
CNT_W, 32, width of both result counters
GATE_BASE, 3, preset gate length in clk cycles for gate_sel=0; gate_sel=1/2/3 give GATE_BASE*10, *100, *1000 (system build uses 10000)
TIMEOUT, 64, max clk cycles spent waiting for an fx edge in WAIT_OPEN or WAIT_CLOSE (system build uses 2**24)

Ports:
clk  in  1  reference clock; all logic on posedge clk
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to start a measurement; honoured only in IDLE
gate_sel  in  2  preset gate select; sampled only when start is accepted
fx  in  1  measured signal, asynchronous to clk
busy  out  1  high in every state except IDLE
valid  out  1  one-cycle pulse; nsig/nref/err are valid in that cycle and held afterwards
nsig  out  CNT_W  number of whole fx periods inside the real gate
nref  out  CNT_W  clk cycles inside the real gate
err  out  2  00 ok, 01 timeout, 10 counter saturation
cont  in  1  only present with AUTO_RESTART_EN; see Optional Feature

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, nsig=0, nref=0, err=00; synchroniser, counters and timers cleared. Reset in any state aborts the measurement the same way.
- fx input: 2-flop synchroniser, then a third flop for edge detection. fx_rise is a 1-cycle pulse, 3 clk after the external edge.
- States: IDLE, WAIT_OPEN, MEASURE, WAIT_CLOSE, DONE.
- IDLE: when start=1, latch gate_len from gate_sel, clear the timeout counter and go to WAIT_OPEN. Start is ignored in every other state.
- WAIT_OPEN: when fx_rise=1, clear cnt_ref, cnt_sig and the gate timer, then go to MEASURE.
- MEASURE and WAIT_CLOSE:
  - cnt_ref increments every cycle.
  - cnt_sig increments on each fx_rise.
  - Both counters saturate at all-ones and set a sticky sat flag.
- MEASURE: the gate timer increments every cycle. When the timer reaches gate_len-1, go to WAIT_CLOSE and clear the timeout counter. If fx_rise occurs in that same cycle it is counted normally but does not close the gate.
- WAIT_CLOSE: when fx_rise=1:
  - nref <= cnt_ref+1 and nsig <= cnt_sig+1, both saturating.
  - err <= (sat ? 10 : 00).
  - Go to DONE.
- Timeout: the timeout counter runs in WAIT_OPEN and WAIT_CLOSE. When it reaches TIMEOUT-1 without an fx_rise: nsig=0, nref=0, err=01, go to DONE. If fx_rise and timeout occur in the same cycle, fx_rise wins.
- DONE: lasts exactly one cycle with valid=1, then returns to IDLE. The result outputs hold until the next DONE.
- Invariant: for an fx period of P clk cycles (integer), nref = nsig*P exactly.
- Latency: from start to valid = wait for first fx_rise + gate_len + wait for closing fx_rise + 1 cycle (DONE).

Optional Feature:
Macro AUTO_RESTART_EN.
- Defined: port cont exists. On leaving DONE, if cont=1 the block goes straight to WAIT_OPEN with the same gate_len and a cleared timeout counter, without needing start; otherwise it goes to IDLE. busy stays 1 across the re-arm.
- Undefined: cont does not exist, and DONE always goes to IDLE.

Test Plan:
- Reset/idle: assert rst for 2 cycles -> busy=0, valid=0, nsig=0, nref=0, err=00; start while rst=1 is ignored.
- Basic, defaults: fx period 4 clk (high 2/low 2), gate_sel=0, pulse start -> exactly one valid pulse with nsig=1, nref=4, err=00; busy falls the cycle after valid.
- Long gate: fx period 4, gate_sel=1 (30 cycles) -> nsig=8, nref=32, err=00. With period 7 -> nsig=5, nref=35.
- Timeout: fx held at 0, start, gate_sel=0 -> valid exactly TIMEOUT cycles after WAIT_OPEN entry, with err=01, nsig=0, nref=0. Separately, stop fx after the gate opens -> err=01 from WAIT_CLOSE.
- Busy/abort: start pulses during MEASURE are ignored (still exactly one valid per accepted start); rst asserted mid-MEASURE -> IDLE next cycle, no valid; a fresh start then yields a correct result.
- AUTO_RESTART_EN with cont=1, fx period 4, gate_sel=0 -> repeated valid pulses each with nsig=1, nref=4 and busy never falling; drop cont -> IDLE after the next valid.

Source files
------------

// File: rtl/eqp_meas_ctrl.sv
// Equal-precision frequency meter measurement sequencer.
// Optional build macro AUTO_RESTART_EN adds the cont port for back-to-back runs.
module eqp_meas_ctrl #(
    parameter int CNT_W     = 32,
    parameter int GATE_BASE = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       gate_sel,
    input  logic             fx,
`ifdef AUTO_RESTART_EN
    input  logic             cont,
`endif
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] nsig,
    output logic [CNT_W-1:0] nref,
    output logic [1:0]       err
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [31:0] GL0 = 32'(GATE_BASE);
    localparam logic [31:0] GL1 = 32'(GATE_BASE * 10);
    localparam logic [31:0] GL2 = 32'(GATE_BASE * 100);
    localparam logic [31:0] GL3 = 32'(GATE_BASE * 1000);

    typedef enum logic [2:0] {
        S_IDLE, S_WOPEN, S_MEAS, S_WCLOSE, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       fx_q, fx_d;
    logic [31:0]      gate_len_q, gate_len_d;
    logic [31:0]      gate_tmr_q, gate_tmr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_ref_q, cnt_ref_d;
    logic [CNT_W-1:0] cnt_sig_q, cnt_sig_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] nsig_q, nsig_d;
    logic [CNT_W-1:0] nref_q, nref_d;
    logic [1:0]       err_q, err_d;

    logic fx_rise, ref_max, sig_max;
    logic [31:0] sel_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fx_q       <= '0;
            gate_len_q <= '0;
            gate_tmr_q <= '0;
            tmo_q      <= '0;
            cnt_ref_q  <= '0;
            cnt_sig_q  <= '0;
            sat_q      <= 1'b0;
            nsig_q     <= '0;
            nref_q     <= '0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            fx_q       <= fx_d;
            gate_len_q <= gate_len_d;
            gate_tmr_q <= gate_tmr_d;
            tmo_q      <= tmo_d;
            cnt_ref_q  <= cnt_ref_d;
            cnt_sig_q  <= cnt_sig_d;
            sat_q      <= sat_d;
            nsig_q     <= nsig_d;
            nref_q     <= nref_d;
            err_q      <= err_d;
        end
    end

    // fx_q[1:0] is the 2-flop synchroniser, fx_q[2] the edge-detect history
    assign fx_rise = fx_q[1] & ~fx_q[2];
    assign ref_max = &cnt_ref_q;
    assign sig_max = &cnt_sig_q;

    always_comb begin
        sel_len = GL0;
        case (gate_sel)
            2'd1:    sel_len = GL1;
            2'd2:    sel_len = GL2;
            2'd3:    sel_len = GL3;
            default: sel_len = GL0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fx_d       = {fx_q[1:0], fx};
        gate_len_d = gate_len_q;
        gate_tmr_d = gate_tmr_q;
        tmo_d      = tmo_q;
        cnt_ref_d  = cnt_ref_q;
        cnt_sig_d  = cnt_sig_q;
        sat_d      = sat_q;
        nsig_d     = nsig_q;
        nref_d     = nref_q;
        err_d      = err_q;

        if (state_q == S_MEAS || state_q == S_WCLOSE) begin
            cnt_ref_d = ref_max ? cnt_ref_q : cnt_ref_q + 1'b1;
            sat_d     = sat_q | ref_max;
            if (fx_rise) begin
                cnt_sig_d = sig_max ? cnt_sig_q : cnt_sig_q + 1'b1;
                sat_d     = sat_q | ref_max | sig_max;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    gate_len_d = sel_len;
                    tmo_d      = '0;
                    state_d    = S_WOPEN;
                end
            end
            S_WOPEN: begin
                tmo_d = tmo_q + 1'b1;
                if (fx_rise) begin
                    cnt_ref_d  = '0;
                    cnt_sig_d  = '0;
                    sat_d      = 1'b0;
                    gate_tmr_d = '0;
                    state_d    = S_MEAS;
                end else if (tmo_q == TMO_LAST) begin
                    nsig_d  = '0;
                    nref_d  = '0;
                    err_d   = 2'b01;
                    state_d = S_DONE;
                end
            end
            S_MEAS: begin
                gate_tmr_d = gate_tmr_q + 1'b1;
                if (gate_tmr_q == gate_len_q - 32'd1) begin
                    tmo_d   = '0;
                    state_d = S_WCLOSE;
                end
            end
            S_WCLOSE: begin
                tmo_d = tmo_q + 1'b1;
                if (fx_rise) begin
                    nref_d  = ref_max ? cnt_ref_q : cnt_ref_q + 1'b1;
                    nsig_d  = sig_max ? cnt_sig_q : cnt_sig_q + 1'b1;
                    err_d   = (sat_q | ref_max | sig_max) ? 2'b10 : 2'b00;
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    nsig_d  = '0;
                    nref_d  = '0;
                    err_d   = 2'b01;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef AUTO_RESTART_EN
                if (cont) begin
                    tmo_d   = '0;
                    state_d = S_WOPEN;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign valid = (state_q == S_DONE);
    assign nsig  = nsig_q;
    assign nref  = nref_q;
    assign err   = err_q;

endmodule

// File: tb/tb_eqp_meas_ctrl.sv
// Randomised bench for eqp_meas_ctrl: edge-indexed reference model plus literal anchors.
// Define AUTO_RESTART_EN to also exercise the cont port.
module tb_eqp_meas_ctrl;

    localparam int CW  = 32;
    localparam int GB  = 3;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    gate_sel = 2'd0;
    logic          fx = 1'b0;
`ifdef AUTO_RESTART_EN
    logic          cont = 1'b0;
`endif
    logic          busy, valid;
    logic [CW-1:0] nsig, nref;
    logic [1:0]    err;

    int checks = 0;
    int failures = 0;

    eqp_meas_ctrl #(.CNT_W(CW), .GATE_BASE(GB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .fx(fx),
`ifdef AUTO_RESTART_EN
        .cont(cont),
`endif
        .busy(busy), .valid(valid), .nsig(nsig), .nref(nref), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // fx waveform: period fx_per clk, high for fx_hi clk, changes away from posedge
    bit fx_en = 1'b0;
    int fx_per = 4, fx_hi = 2, fx_ph = 0;
    always @(posedge clk) begin
        #2;
        if (fx_en) begin
            fx_ph = (fx_ph + 1) % fx_per;
            fx = (fx_ph < fx_hi);
        end else begin
            fx_ph = 0;
            fx = 1'b0;
        end
    end

    // Reference model: everything is expressed as absolute posedge numbers.
    // A rise acts at edge e when fx was 1 at edge e-2 and 0 at edge e-3.
    typedef enum {M_IDLE, M_WOPEN, M_MEAS, M_WCLOSE, M_DONE} mph_t;
    mph_t m_ph = M_IDLE;
    bit   live = 1'b0;
    bit   fxh[8];
    int   edge_n = 0;
    int   arm = 0, e0 = 0, acc = 0, glen = GB;
    longint e_nsig = 0, e_nref = 0, e_err = 0;

    always @(posedge clk) begin : model
        bit rise;
        bit cont_v;
`ifdef AUTO_RESTART_EN
        cont_v = cont;
`else
        cont_v = 1'b0;
`endif
        fxh[edge_n % 8] = rst ? 1'b0 : fx;
        rise = (edge_n >= 3) && fxh[(edge_n - 2) % 8] && !fxh[(edge_n - 3) % 8];
        live = 1'b1;
        if (rst) begin
            m_ph = M_IDLE;
            e_nsig = 0;
            e_nref = 0;
            e_err = 0;
        end else begin
            case (m_ph)
                M_IDLE: if (start) begin
                    m_ph = M_WOPEN;
                    arm = edge_n;
                    glen = GB;
                    for (int i = 0; i < int'(gate_sel); i++) glen = glen * 10;
                end
                M_WOPEN: if (rise) begin
                    m_ph = M_MEAS;
                    e0 = edge_n;
                    acc = 1;
                end else if (edge_n == arm + TMO) begin
                    e_nsig = 0; e_nref = 0; e_err = 1;
                    m_ph = M_DONE;
                end
                M_MEAS: begin
                    if (rise) acc++;
                    if (edge_n == e0 + glen) begin
                        m_ph = M_WCLOSE;
                        arm = edge_n;
                    end
                end
                M_WCLOSE: if (rise) begin
                    e_nsig = acc; e_nref = edge_n - e0; e_err = 0;
                    m_ph = M_DONE;
                end else if (edge_n == arm + TMO) begin
                    e_nsig = 0; e_nref = 0; e_err = 1;
                    m_ph = M_DONE;
                end
                M_DONE: if (cont_v) begin
                    m_ph = M_WOPEN;
                    arm = edge_n;
                end else begin
                    m_ph = M_IDLE;
                end
                default: m_ph = M_IDLE;
            endcase
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_busy", busy, (m_ph != M_IDLE));
            chk("cyc_valid", valid, (m_ph == M_DONE));
            chk("cyc_nsig", nsig, e_nsig);
            chk("cyc_nref", nref, e_nref);
            chk("cyc_err", err, e_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_fx(input bit en, input int per, input int hi);
        fx_en = 1'b0;
        cyc(4);
        fx_per = per;
        fx_hi = hi;
        fx_en = en;
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        @(negedge clk);
        gate_sel = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int bound, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        while (n < bound && !ok) begin
            @(negedge clk);
            n++;
            if (valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: no valid within %0d cycles", nm, bound);
        end
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n;
        n = 0;
        while (n < bound && busy) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s: still busy after %0d cycles", nm, bound);
        end
    endtask

    task automatic expect_res(input string nm, input longint s, input longint r, input longint e);
        chk({nm, "_nsig"}, nsig, s);
        chk({nm, "_nref"}, nref, r);
        chk({nm, "_err"}, err, e);
    endtask

    initial begin
        int n;
        // reset with start held high: must be ignored
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        expect_res("rst", 0, 0, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // basic: period 4, gate 3
        set_fx(1'b1, 4, 2);
        cyc(3);
        pulse_start(2'd0);
        wait_valid("basic", 200, n);
        expect_res("basic", 1, 4, 0);
        @(negedge clk);
        chk("basic_busy_fall", busy, 0);
        chk("basic_one_valid", valid, 0);

        // long gate: 30 cycles
        pulse_start(2'd1);
        wait_valid("long4", 300, n);
        expect_res("long4", 8, 32, 0);
        cyc(2);
        set_fx(1'b1, 7, 3);
        cyc(3);
        pulse_start(2'd1);
        wait_valid("long7", 300, n);
        expect_res("long7", 5, 35, 0);
        cyc(2);

        // WAIT_OPEN timeout: latency from WAIT_OPEN entry is exactly TMO
        set_fx(1'b0, 4, 2);
        cyc(4);
        pulse_start(2'd0);
        wait_valid("tmo_open", 300, n);
        chk("tmo_open_lat", n, TMO);
        expect_res("tmo_open", 0, 0, 1);
        cyc(2);

        // WAIT_CLOSE timeout: fx stops after the gate opened
        set_fx(1'b1, 4, 2);
        cyc(3);
        pulse_start(2'd1);
        cyc(10);
        fx_en = 1'b0;
        wait_valid("tmo_close", 300, n);
        expect_res("tmo_close", 0, 0, 1);
        cyc(2);

        // restarts ignored while busy, then abort with reset mid-MEASURE
        set_fx(1'b1, 4, 2);
        cyc(3);
        pulse_start(2'd1);
        cyc(8);
        pulse_start(2'd0);
        cyc(4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(3);
        pulse_start(2'd1);
        wait_valid("after_abort", 300, n);
        expect_res("after_abort", 8, 32, 0);
        cyc(2);

`ifdef AUTO_RESTART_EN
        cont = 1'b1;
        pulse_start(2'd0);
        repeat (4) begin
            wait_valid("auto", 200, n);
            expect_res("auto", 1, 4, 0);
            @(negedge clk);
            chk("auto_busy", busy, 1);
        end
        wait_valid("auto_last", 200, n);
        cont = 1'b0;
        @(negedge clk);
        chk("auto_stop_busy", busy, 0);
        cyc(2);
`endif

        // randomised runs: per-cycle model comparison does the checking
        for (int it = 0; it < 40; it++) begin
            int per;
            per = $urandom_range(2, 14);
            set_fx($urandom_range(0, 9) != 0, per, $urandom_range(1, per - 1));
`ifdef AUTO_RESTART_EN
            cont = $urandom_range(0, 1);
`endif
            cyc($urandom_range(0, 5));
            pulse_start(($urandom_range(0, 7) == 0) ? 2'd2 : 2'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) begin
                cyc($urandom_range(1, 40));
                rst = 1'b1;
                cyc(2);
                rst = 1'b0;
            end else begin
                repeat (3) begin
                    cyc($urandom_range(1, 20));
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                cyc($urandom_range(1, 30));
                fx_en = 1'b0;
            end
`ifdef AUTO_RESTART_EN
            cyc($urandom_range(0, 60));
            cont = 1'b0;
`endif
            wait_idle("rand_idle", 2000);
        end

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
